// File: rtl/pc_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_unit_pkg
// Purpose  : Shared CPU fetch definitions: the default reset vector, the
//            fetch state encoding, the response queue depth and small
//            helpers used by the fetch unit and its queue.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package pc_fetch_unit_pkg;

    // First fetch address after reset unless overridden on the top module.
    localparam logic [31:0] c_RESET_VECTOR_DEFAULT = 32'h0000_0000;

    // Response queue depth; also the total fetch credit (in flight + queued).
    localparam int c_QUEUE_DEPTH = 2;

    // One queue entry is {pc, instruction word}.
    localparam int c_ENTRY_W = 64;

    typedef enum logic [0:0] {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_t;

    // Sequential word step; wraps modulo 2^32 by construction.
    function automatic logic [31:0] next_word_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage : pc_fetch_unit_pkg
`default_nettype wire

// File: rtl/pc_fetch_unit_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Purpose  : 2-entry synchronous FIFO holding {pc, instruction} pairs
//            between the instruction memory and decode.
// Ports    : clk, reset      - clock, asynchronous active-high reset
//            push, push_data - write an entry (accepted when full if popping)
//            pop             - remove the head entry (ignored when empty)
//            flush           - empty the queue; wins over push and pop
//            count           - number of valid entries (0..2)
//            head_data       - head entry, valid when count != 0
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue
    import pc_fetch_unit_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic [c_ENTRY_W-1:0] push_data,
    input  logic                 pop,
    input  logic                 flush,
    output logic [1:0]           count,
    output logic [c_ENTRY_W-1:0] head_data
);

    logic [c_ENTRY_W-1:0] r_mem [0:c_QUEUE_DEPTH-1];
    logic                 r_rd_ptr;
    logic                 r_wr_ptr;
    logic [1:0]           r_count;

    logic w_full;
    logic w_empty;
    logic w_do_push;
    logic w_do_pop;

    assign w_full    = (r_count == 2'(c_QUEUE_DEPTH));
    assign w_empty   = (r_count == 2'd0);
    // When full, the slot being written is the one popped this cycle.
    assign w_do_push = push && (!w_full || pop);
    assign w_do_pop  = pop && !w_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (flush) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign count     = r_count;
    assign head_data = r_mem[r_rd_ptr];

endmodule : fetch_queue
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_unit
// Purpose  : Sequential instruction fetch with branch redirect. Issues word
//            requests to instruction memory under a 2-deep credit (in-flight
//            plus queued), drops responses belonging to requests issued
//            before a redirect, and presents in-order {pc, word} to decode.
// Ports    : clk, reset                       - clock, async active-high reset
//            redirect_valid/redirect_address  - taken branch/jump target
//            imem_req_valid/ready/address     - memory request channel
//            imem_resp_valid/imem_resp_data   - in-order response, no stall
//            inst_valid/ready/data/pc         - decode channel
// Revision : 1.0 - initial release
// ============================================================================
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = c_RESET_VECTOR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_address,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_address,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc
);

    fetch_state_t r_state;
    logic [31:0]  r_fetch_pc;     // address of the next request
    logic [31:0]  r_resp_pc;      // address of the next kept response
    logic [1:0]   r_outstanding;  // requests accepted, response not yet seen
    logic [1:0]   r_discard;      // in-flight responses still to be dropped

    logic [1:0]           w_q_count;
    logic [c_ENTRY_W-1:0] w_q_head;
    logic [31:0]          w_target;
    logic                 w_credit_ok;
    logic                 w_req_fire;
    logic                 w_push;
    logic                 w_pop;
    logic [1:0]           w_out_next;
    logic                 w_unused_addr_bits;

    assign w_target           = {redirect_address[31:2], 2'b00};
    assign w_unused_addr_bits = ^redirect_address[1:0];

    // Credit covers queued words too, so a response can never find the
    // queue full without a same-cycle pop.
    assign w_credit_ok = ({1'b0, r_outstanding} + {1'b0, w_q_count}) < 3'(c_QUEUE_DEPTH);

    assign imem_req_valid   = (r_state == ST_RUN) && w_credit_ok;
    assign imem_req_address = r_fetch_pc;
    assign w_req_fire       = imem_req_valid && imem_req_ready;

    // A response arriving in a redirect cycle belongs to the old stream.
    assign w_push = imem_resp_valid && (r_discard == 2'd0) && !redirect_valid;
    assign w_pop  = inst_valid && inst_ready;

    always_comb begin
        w_out_next = r_outstanding;
        case ({w_req_fire, imem_resp_valid})
            2'b10:   w_out_next = r_outstanding + 2'd1;
            2'b01:   w_out_next = r_outstanding - 2'd1;
            default: w_out_next = r_outstanding;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_BOOT;
            r_fetch_pc    <= RESET_VECTOR;
            r_resp_pc     <= RESET_VECTOR;
            r_outstanding <= 2'd0;
            r_discard     <= 2'd0;
        end else begin
            case (r_state)
                ST_BOOT: r_state <= ST_RUN;
                default: r_state <= ST_RUN;
            endcase

            r_outstanding <= w_out_next;

            if (redirect_valid) begin
                // Everything in flight after this edge, including a request
                // accepted right now, was fetched from the old path.
                r_fetch_pc <= w_target;
                r_resp_pc  <= w_target;
                r_discard  <= w_out_next;
            end else begin
                if (w_req_fire) begin
                    r_fetch_pc <= next_word_pc(r_fetch_pc);
                end
                if (imem_resp_valid) begin
                    if (r_discard != 2'd0) begin
                        r_discard <= r_discard - 2'd1;
                    end else begin
                        r_resp_pc <= next_word_pc(r_resp_pc);
                    end
                end
            end
        end
    end

    fetch_queue u_fetch_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data ({r_resp_pc, imem_resp_data}),
        .pop       (w_pop),
        .flush     (redirect_valid),
        .count     (w_q_count),
        .head_data (w_q_head)
    );

    assign inst_valid = (w_q_count != 2'd0);
    assign inst_pc    = w_q_head[63:32];
    assign inst_data  = w_q_head[31:0];

endmodule : pc_fetch_unit
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_fetch_unit
// Purpose  : Directed self-checking bench for pc_fetch_unit with an in-order
//            instruction memory model (word = address ^ c_K).
// Ports    : none (testbench top)
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_unit;

    localparam logic [31:0] c_K = 32'h5A5A_A5A5;

    logic        clk;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_address;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_address;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    logic        resp_en;
    logic [31:0] pend [$];

    int n_tests = 0;
    int n_fail  = 0;
    int nfire;

    pc_fetch_unit #(.RESET_VECTOR(32'h0000_0000)) dut (
        .clk              (clk),
        .reset            (reset),
        .redirect_valid   (redirect_valid),
        .redirect_address (redirect_address),
        .imem_req_valid   (imem_req_valid),
        .imem_req_ready   (imem_req_ready),
        .imem_req_address (imem_req_address),
        .imem_resp_valid  (imem_resp_valid),
        .imem_resp_data   (imem_resp_data),
        .inst_valid       (inst_valid),
        .inst_ready       (inst_ready),
        .inst_data        (inst_data),
        .inst_pc          (inst_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // In-order memory: 1-cycle latency when resp_en, responses held otherwise.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            pend.delete();
            imem_resp_valid <= 1'b0;
            imem_resp_data  <= 32'h0;
        end else begin
            if (imem_req_valid && imem_req_ready)
                pend.push_back(imem_req_address);
            if (resp_en && pend.size() > 0) begin
                imem_resp_valid <= 1'b1;
                imem_resp_data  <= pend.pop_front() ^ c_K;
            end else begin
                imem_resp_valid <= 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for the next decode word, check pc/data, step past its pop.
    task automatic get_inst(input string tag, input logic [31:0] exp_pc);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (inst_valid) begin
                chk({tag, "_pc"}, inst_pc, exp_pc);
                chk({tag, "_data"}, inst_data, exp_pc ^ c_K);
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!found) chk1({tag, "_timeout"}, inst_valid, 1'b1);
        else @(negedge clk);
    endtask

    // Leaves the bench at the negedge right after release (BOOT cycle).
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        redirect_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset            = 1'b1;
        redirect_valid   = 1'b0;
        redirect_address = 32'h0;
        imem_req_ready   = 1'b1;
        inst_ready       = 1'b1;
        resp_en          = 1'b1;

        // ---- reset state and straight-line fetch ----
        repeat (2) @(negedge clk);
        chk1("rst_req_valid",  imem_req_valid, 1'b0);
        chk1("rst_inst_valid", inst_valid, 1'b0);
        chk ("rst_inst_data",  inst_data, 32'h0);
        chk ("rst_inst_pc",    inst_pc, 32'h0);
        chk ("rst_req_addr",   imem_req_address, 32'h0);
        reset = 1'b0;
        chk1("t1_boot_no_req", imem_req_valid, 1'b0);
        @(negedge clk);
        chk1("t1_req0_valid", imem_req_valid, 1'b1);
        chk ("t1_req0_addr",  imem_req_address, 32'h0);
        @(negedge clk);
        chk1("t1_req1_valid", imem_req_valid, 1'b1);
        chk ("t1_req1_addr",  imem_req_address, 32'h4);
        @(negedge clk);
        get_inst("t1_i0", 32'h0);
        get_inst("t1_i1", 32'h4);
        get_inst("t1_i2", 32'h8);

        // ---- decode stall: exactly two words fetched ----
        inst_ready = 1'b0;
        do_reset();
        nfire = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) nfire++;
        end
        chk ("t2_fire_count",  32'(nfire), 32'd2);
        chk1("t2_req_blocked", imem_req_valid, 1'b0);
        chk1("t2_inst_valid",  inst_valid, 1'b1);
        chk ("t2_head_pc",     inst_pc, 32'h0);
        chk ("t2_head_data",   inst_data, 32'h0 ^ c_K);
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
        chk ("t2_pop_pc",       inst_pc, 32'h4);
        chk ("t2_pop_data",     inst_data, 32'h4 ^ c_K);
        chk1("t2_req_resumed",  imem_req_valid, 1'b1);
        chk ("t2_req_addr",     imem_req_address, 32'h8);
        inst_ready = 1'b1;
        get_inst("t2_i1", 32'h4);
        get_inst("t2_i2", 32'h8);

        // ---- redirect with two requests outstanding ----
        resp_en = 1'b0;
        do_reset();
        @(negedge clk);
        chk ("t3_req0_addr", imem_req_address, 32'h0);
        @(negedge clk);
        chk ("t3_req1_addr", imem_req_address, 32'h4);
        @(negedge clk);
        chk1("t3_no_credit", imem_req_valid, 1'b0);
        chk1("t3_no_inst",   inst_valid, 1'b0);
        redirect_valid   = 1'b1;
        redirect_address = 32'h0000_0103;
        @(negedge clk);
        redirect_valid = 1'b0;
        resp_en        = 1'b1;
        chk ("t3_target_addr", imem_req_address, 32'h0000_0100);
        chk1("t3_still_no_credit", imem_req_valid, 1'b0);
        get_inst("t3_i0", 32'h0000_0100);
        get_inst("t3_i1", 32'h0000_0104);

        // ---- redirect together with a handshake and a response ----
        do_reset();
        @(negedge clk);
        chk ("t4_req0_addr", imem_req_address, 32'h0);
        @(negedge clk);
        chk1("t4_req1_valid", imem_req_valid, 1'b1);
        chk ("t4_req1_addr",  imem_req_address, 32'h4);
        redirect_valid   = 1'b1;
        redirect_address = 32'h0000_0200;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk1("t4_tgt_valid", imem_req_valid, 1'b1);
        chk ("t4_tgt_addr",  imem_req_address, 32'h0000_0200);
        chk1("t4_flushed",   inst_valid, 1'b0);
        get_inst("t4_i0", 32'h0000_0200);
        get_inst("t4_i1", 32'h0000_0204);

        // ---- redirect near the top of the address space ----
        do_reset();
        @(negedge clk);
        chk ("t5_req0_addr", imem_req_address, 32'h0);
        redirect_valid   = 1'b1;
        redirect_address = 32'hFFFF_FFF8;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk ("t5_tgt_addr", imem_req_address, 32'hFFFF_FFF8);
        get_inst("t5_i0", 32'hFFFF_FFF8);
        get_inst("t5_i1", 32'hFFFF_FFFC);
        get_inst("t5_i2", 32'h0000_0000);

        // ---- asynchronous reset in the middle of a stall ----
        inst_ready = 1'b0;
        do_reset();
        repeat (6) @(negedge clk);
        chk1("t6_stalled", inst_valid, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk1("t6_async_req_valid",  imem_req_valid, 1'b0);
        chk1("t6_async_inst_valid", inst_valid, 1'b0);
        chk ("t6_async_inst_data",  inst_data, 32'h0);
        chk ("t6_async_inst_pc",    inst_pc, 32'h0);
        chk ("t6_async_req_addr",   imem_req_address, 32'h0);
        @(negedge clk);
        reset      = 1'b0;
        inst_ready = 1'b1;
        chk1("t6_boot_no_req", imem_req_valid, 1'b0);
        @(negedge clk);
        chk1("t6_req0_valid", imem_req_valid, 1'b1);
        chk ("t6_req0_addr",  imem_req_address, 32'h0);
        get_inst("t6_i0", 32'h0);
        get_inst("t6_i1", 32'h4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_pc_fetch_unit
`default_nettype wire
